// File: rtl/pcpi_issue_stage.sv
// PCPI front end that claims M-extension and custom-0 instructions and hands them
// to a coprocessor controller. Define PCPI_ISSUE_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
`timescale 1ns/1ps
module pcpi_issue_stage #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_ready,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        cp_valid,
  output logic [31:0] cp_insn,
  output logic [31:0] cp_rs1,
  output logic [31:0] cp_rs2,
  input  logic        cp_ready,
  input  logic        cp_wr,
  input  logic [31:0] cp_rd,
  input  logic        cp_busy
);

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_MULDIV   = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

  state_t      state;
  logic        armed;
  logic        in_flight;
  logic        ready_q;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        decode_hit;

  // Busy is informational only; nothing in this stage reacts to it.
  logic unused_cp_busy;
  assign unused_cp_busy = cp_busy;

  assign decode_hit = ((pcpi_insn[6:0] == OPC_OP) && (pcpi_insn[31:25] == F7_MULDIV))
                   || (pcpi_insn[6:0] == OPC_CUSTOM0);

`ifdef PCPI_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  assign wait_cnt_nxt = wait_cnt + 8'd1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      armed     <= 1'b1;
      in_flight <= 1'b0;
      ready_q   <= 1'b0;
      req_insn  <= '0;
      req_rs1   <= '0;
      req_rs2   <= '0;
      rsp_wr    <= 1'b0;
      rsp_rd    <= '0;
`ifdef PCPI_ISSUE_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pcpi_valid && decode_hit && armed) begin
            req_insn  <= pcpi_insn;
            req_rs1   <= pcpi_rs1;
            req_rs2   <= pcpi_rs2;
            in_flight <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!pcpi_valid) begin
            in_flight <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            state     <= ST_WAIT;
          end
`ifdef PCPI_ISSUE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          // Abort beats a same-cycle response: that response is already consumed, so skip DRAIN.
          if (!pcpi_valid) begin
            in_flight <= 1'b0;
            state     <= cp_ready ? ST_IDLE : ST_DRAIN;
          end else if (cp_ready) begin
            in_flight <= 1'b0;
            rsp_wr    <= cp_wr;
            rsp_rd    <= cp_rd;
            ready_q   <= 1'b1;
            armed     <= 1'b0;
            state     <= ST_RESP;
          end
`ifdef PCPI_ISSUE_TIMEOUT_EN
          else if (wait_cnt_nxt == TIMEOUT_LIMIT) begin
            in_flight <= 1'b0;
            wait_cnt  <= wait_cnt_nxt;
            state     <= ST_DRAIN;
          end else begin
            wait_cnt  <= wait_cnt_nxt;
          end
`endif
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (cp_ready) begin
            armed <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          in_flight <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
      // NOTE: non-blocking, so this later assignment overrides any clear above in the same cycle.
      if (!pcpi_valid) armed <= 1'b1;
    end
  end

  // in_flight is high exactly in ISSUE/WAIT, ready_q exactly in RESP.
  assign cp_valid   = in_flight;
  assign pcpi_wait  = in_flight;
  assign cp_insn    = in_flight ? req_insn : '0;
  assign cp_rs1     = in_flight ? req_rs1  : '0;
  assign cp_rs2     = in_flight ? req_rs2  : '0;
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q & rsp_wr;
  assign pcpi_rd    = ready_q ? rsp_rd : '0;

  a_ready_single: assert property (@(posedge clk) disable iff (!resetn) ready_q |=> !ready_q);
  a_issue_single: assert property (@(posedge clk) disable iff (!resetn)
                                   (state == ST_ISSUE) |=> (state != ST_ISSUE));

endmodule

// File: tb/tb_pcpi_issue_stage.sv
// Scoreboard bench for pcpi_issue_stage: expected responses are queued at issue
// and popped when pcpi_ready is seen; the bench also stands in for the coprocessor.
`timescale 1ns/1ps
module tb_pcpi_issue_stage;

  localparam int         TIMEOUT   = 4;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_CUST0 = 7'b0001011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] F7_M      = 7'b0000001;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        cp_valid;
  logic [31:0] cp_insn;
  logic [31:0] cp_rs1;
  logic [31:0] cp_rs2;
  logic        cp_ready = 1'b0;
  logic        cp_wr = 1'b0;
  logic [31:0] cp_rd = '0;
  logic        cp_busy = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] sb_q[$];
  logic        prev_ready = 1'b0;

  pcpi_issue_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .cp_valid   (cp_valid),
    .cp_insn    (cp_insn),
    .cp_rs1     (cp_rs1),
    .cp_rs2     (cp_rs2),
    .cp_ready   (cp_ready),
    .cp_wr      (cp_wr),
    .cp_rd      (cp_rd),
    .cp_busy    (cp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  // Coprocessor stand-in: M ops report a write, custom-0 returns a^b without a write.
  function automatic logic [32:0] cop_model(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    if (insn[6:0] == OPC_CUST0) return {1'b0, a ^ b};
    case (insn[14:12])
      3'd0:    r = a * b;
      3'd5:    r = (b == 0) ? '1 : a / b;
      3'd6:    r = (b == 0) ? a : 32'($signed(a) % $signed(b));
      default: r = '0;
    endcase
    return {1'b1, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (pcpi_ready) begin
      check("ready_pulse", {63'd0, prev_ready}, 64'd0);
      if (sb_q.size() == 0) check("spurious_ready", {63'd0, pcpi_ready}, 64'd0);
      else                  check("resp_wr_rd", {31'd0, pcpi_wr, pcpi_rd}, {31'd0, sb_q.pop_front()});
    end else begin
      check("rd_wr_idle", {31'd0, pcpi_wr, pcpi_rd}, 64'd0);
    end
    prev_ready = pcpi_ready;
  end

  // Issue one op, respond on WAIT cycle k; leaves the DUT in RESP with pcpi_valid high.
  task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int k, input logic [32:0] exp,
                        input bit ready_in_issue);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    sb_q.push_back(exp);
    tick();
    check({tag, "_cp_valid"}, {63'd0, cp_valid}, 64'd1);
    check({tag, "_cp_req"}, {cp_insn, cp_rs1}, {insn, a});
    pcpi_rs1 = ~a;
    pcpi_rs2 = ~b;
    if (ready_in_issue) begin
      cp_ready = 1'b1;
      cp_rd    = 32'h1234_5678;
    end
    tick();
    cp_ready = 1'b0;
    cp_rd    = '0;
    check({tag, "_cp_rs2"}, {32'd0, cp_rs2}, {32'd0, b});
    for (int i = 1; i < k; i++) begin
      check({tag, "_wait"}, {62'd0, cp_valid, pcpi_wait}, 64'd3);
      tick();
    end
    check({tag, "_wait_last"}, {62'd0, cp_valid, pcpi_wait}, 64'd3);
    {cp_wr, cp_rd} = cop_model(cp_insn, cp_rs1, cp_rs2);
    cp_ready = 1'b1;
    tick();
    cp_ready = 1'b0;
    cp_wr    = 1'b0;
    cp_rd    = '0;
    check({tag, "_ready"}, {63'd0, pcpi_ready}, 64'd1);
    check({tag, "_cp_drop"}, {62'd0, cp_valid, pcpi_wait}, 64'd0);
  endtask

  task automatic finish_op();
    pcpi_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 resetn = 1'b0;
    #2;
    check("rst_flags", {60'd0, pcpi_ready, pcpi_wr, pcpi_wait, cp_valid}, 64'd0);
    check("rst_data", {pcpi_rd, cp_insn}, 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    // MUL 3*5 answered on the 4th WAIT cycle.
    run_op("mul", enc(F7_M, 3'd0, OPC_OP), 32'd3, 32'd5, 4, {1'b1, 32'd15}, 1'b0);

    // Core keeps presenting the same instruction: no reissue until it drops valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_reissue", {63'd0, cp_valid}, 64'd0);
    end
    finish_op();
    run_op("divu", enc(F7_M, 3'd5, OPC_OP), 32'd20, 32'd3, 2, {1'b1, 32'd6}, 1'b0);
    finish_op();

    // Non-hit instructions are left alone; a stray cp_ready in IDLE is ignored.
    pcpi_valid = 1'b1;
    pcpi_insn  = enc(7'd0, 3'd0, OPC_IMM);
    for (int i = 0; i < 10; i++) begin
      cp_ready = (i == 4);
      tick();
      check("addi_ignored", {62'd0, cp_valid, pcpi_wait}, 64'd0);
    end
    cp_ready  = 1'b0;
    pcpi_insn = enc(7'b0100000, 3'd0, OPC_OP);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sub_ignored", {62'd0, cp_valid, pcpi_wait}, 64'd0);
    end
    finish_op();

    // Custom-0 with arbitrary func7, cp_ready during ISSUE must be ignored.
    run_op("cust", {7'b1010101, 5'd2, 5'd1, 3'b010, 5'd3, OPC_CUST0},
           32'hF0F0_0000, 32'h0000_0F0F, 1, {1'b0, 32'hF0F0_0F0F}, 1'b1);
    finish_op();

    // Abort and cp_ready in the same WAIT cycle: straight back to IDLE.
    pcpi_valid = 1'b1;
    pcpi_insn  = enc(F7_M, 3'd0, OPC_OP);
    pcpi_rs1   = 32'd7;
    pcpi_rs2   = 32'd6;
    tick();
    tick();
    pcpi_valid = 1'b0;
    cp_ready   = 1'b1;
    cp_wr      = 1'b1;
    cp_rd      = 32'h0BAD;
    tick();
    cp_ready = 1'b0;
    cp_wr    = 1'b0;
    cp_rd    = '0;
    check("abort_same_cyc", {61'd0, cp_valid, pcpi_wait, pcpi_ready}, 64'd0);
    run_op("mul_after_abort", enc(F7_M, 3'd0, OPC_OP), 32'd6, 32'd7, 1, {1'b1, 32'd42}, 1'b0);
    finish_op();

    // Abort on the 2nd WAIT cycle, late response is discarded.
    pcpi_valid = 1'b1;
    pcpi_insn  = enc(F7_M, 3'd0, OPC_OP);
    pcpi_rs1   = 32'd9;
    pcpi_rs2   = 32'd9;
    tick();
    tick();
    tick();
    pcpi_valid = 1'b0;
    tick();
    check("abort_drain", {62'd0, cp_valid, pcpi_wait}, 64'd0);
    tick();
    tick();
    cp_ready = 1'b1;
    cp_wr    = 1'b1;
    cp_rd    = 32'hDEAD_BEEF;
    tick();
    cp_ready = 1'b0;
    cp_wr    = 1'b0;
    cp_rd    = '0;
    check("drain_discard", {31'd0, pcpi_ready, pcpi_rd}, 64'd0);
    tick();

    // Reset mid-WAIT clears outputs without a clock edge.
    pcpi_valid = 1'b1;
    pcpi_insn  = enc(F7_M, 3'd5, OPC_OP);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    tick();
    tick();
    tick();
    #2 resetn = 1'b0;
    #1;
    check("rst_async", {61'd0, cp_valid, pcpi_wait, pcpi_ready}, 64'd0);
    pcpi_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    run_op("rem", enc(F7_M, 3'd6, OPC_OP), 32'hFFFF_FFF9, 32'd2, 3, {1'b1, 32'hFFFF_FFFF}, 1'b0);
    finish_op();

    // Unanswered request: timeout to DRAIN, or wait indefinitely without the feature.
    pcpi_valid = 1'b1;
    pcpi_insn  = enc(F7_M, 3'd0, OPC_OP);
    pcpi_rs1   = 32'd4;
    pcpi_rs2   = 32'd4;
    tick();
`ifdef PCPI_ISSUE_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      check("to_wait", {63'd0, pcpi_wait}, 64'd1);
    end
    tick();
    check("to_drain", {62'd0, cp_valid, pcpi_wait}, 64'd0);
    tick();
    tick();
    check("to_drain_hold", {62'd0, pcpi_wait, pcpi_ready}, 64'd0);
    cp_ready = 1'b1;
    cp_wr    = 1'b1;
    cp_rd    = 32'd77;
    tick();
    cp_ready = 1'b0;
    cp_wr    = 1'b0;
    cp_rd    = '0;
    check("to_discard", {31'd0, pcpi_ready, pcpi_rd}, 64'd0);
    finish_op();
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_timeout", {62'd0, cp_valid, pcpi_wait}, 64'd3);
    end
    sb_q.push_back({1'b1, 32'd16});
    {cp_wr, cp_rd} = cop_model(cp_insn, cp_rs1, cp_rs2);
    cp_ready = 1'b1;
    tick();
    cp_ready = 1'b0;
    cp_wr    = 1'b0;
    cp_rd    = '0;
    check("long_wait_ready", {63'd0, pcpi_ready}, 64'd1);
    finish_op();
`endif

    // Back in IDLE and accepting.
    run_op("cust_final", {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, OPC_CUST0},
           32'h0000_00FF, 32'h0000_000F, 2, {1'b0, 32'h0000_00F0}, 1'b0);
    finish_op();
    tick();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
